// File: rtl/axis_strm_gen_chk_pkg.sv
// Shared types, register map and pattern helpers for the AXI-Stream generator/checker.
package axis_strm_gen_chk_pkg;

    localparam int unsigned AXIS_DATA_W = 512;
    localparam int unsigned TDEST_W     = 8;
    localparam int unsigned TID_W       = 7;
    localparam int unsigned REG_ADDR_W  = 32;
    localparam int unsigned REG_DATA_W  = 64;
    localparam int unsigned PAT_W       = 32;
    localparam int unsigned IDX_W       = 16;
    localparam int unsigned GAP_W       = 16;
    localparam int unsigned CYC_W       = 48;
    localparam int unsigned ERR_W       = 32;

    localparam logic [REG_ADDR_W-1:0] ADDR_TX_COUNT  = 32'h00;
    localparam logic [REG_ADDR_W-1:0] ADDR_RX_COUNT  = 32'h08;
    localparam logic [REG_ADDR_W-1:0] ADDR_TX_DEST   = 32'h10;
    localparam logic [REG_ADDR_W-1:0] ADDR_PKT_LEN   = 32'h18;
    localparam logic [REG_ADDR_W-1:0] ADDR_TX_GAP    = 32'h20;
    localparam logic [REG_ADDR_W-1:0] ADDR_CTRL      = 32'h28;
    localparam logic [REG_ADDR_W-1:0] ADDR_TX_CYC    = 32'h30;
    localparam logic [REG_ADDR_W-1:0] ADDR_RX_CYC    = 32'h38;
    localparam logic [REG_ADDR_W-1:0] ADDR_RX_PKTS   = 32'h40;
    localparam logic [REG_ADDR_W-1:0] ADDR_ERR_COUNT = 32'h48;
    localparam logic [REG_ADDR_W-1:0] ADDR_FIRST_ERR = 32'h50;
    localparam logic [REG_ADDR_W-1:0] ADDR_RX_LAST   = 32'h58;

    localparam int unsigned CTRL_RR_DEST = 0;
    localparam int unsigned CTRL_CHK_EN  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } gen_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  isWrite;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic                  valid;
        logic [REG_DATA_W-1:0] data;
    } SoftRegResp;

    typedef struct packed {
        logic                   tvalid;
        logic [AXIS_DATA_W-1:0] tdata;
        logic [TID_W-1:0]       tid;
        logic [TDEST_W-1:0]     tdest;
        logic                   tlast;
    } axi_stream_t;

    typedef struct packed {
        logic [IDX_W-1:0] pkt;
        logic [IDX_W-1:0] beat;
    } pat_t;

    function automatic logic [PAT_W-1:0] pat_pack(input pat_t p);
        return {p.pkt, p.beat};
    endfunction

    function automatic pat_t pat_unpack(input logic [PAT_W-1:0] w);
        pat_t p;
        p.pkt  = w[PAT_W-1:IDX_W];
        p.beat = w[IDX_W-1:0];
        return p;
    endfunction

endpackage

// File: rtl/axis_strm_chk.sv
// Per-ID receive checker: expected {pkt, beat} table, registered compare, first-error capture.
module axis_strm_chk
    import axis_strm_gen_chk_pkg::*;
#(
    parameter int unsigned NUM_ID = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_chk_en,
    input  logic [IDX_W-1:0]      i_pkt_len,
    input  logic                  i_vld,
    input  logic [TID_W-1:0]      i_tid,
    input  logic [PAT_W-1:0]      i_word,
    input  logic                  i_tlast,
    output logic                  o_err_pulse,
    output logic [REG_DATA_W-1:0] o_first_err
);

    localparam int unsigned ID_W = (NUM_ID > 1) ? $clog2(NUM_ID) : 1;

    pat_t            r_exp [NUM_ID];
    logic [ID_W-1:0] w_idx;
    pat_t            w_exp;
    pat_t            w_rx;
    pat_t            w_nxt;
    logic            w_err;

    // Compare against the table entry for this tid and compute the resync value.
    always_comb begin
        w_idx = i_tid[ID_W-1:0];
        w_exp = r_exp[w_idx];
        w_rx  = pat_unpack(i_word);
        w_err = i_vld && i_chk_en &&
                ((i_word != pat_pack(w_exp)) || (i_tlast != (w_exp.beat == i_pkt_len)));
        w_nxt = w_rx;
        if (i_tlast) begin
            w_nxt.pkt  = w_rx.pkt + IDX_W'(1);
            w_nxt.beat = '0;
        end else begin
            w_nxt.beat = w_rx.beat + IDX_W'(1);
        end
    end

    // Resync to the received word so one dropped beat costs exactly one error.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            for (int unsigned i = 0; i < NUM_ID; i++) begin
                r_exp[i] <= '0;
            end
            o_err_pulse <= 1'b0;
            o_first_err <= '0;
        end else begin
            o_err_pulse <= w_err;
            if (i_vld) begin
                r_exp[w_idx] <= w_nxt;
            end
            if (w_err && !o_first_err[REG_DATA_W-1]) begin
                o_first_err <= {1'b1, i_tid, 24'd0, i_word};
            end
        end
    end

endmodule

// File: rtl/axis_strm_gen_chk.sv
// AXI-Stream traffic generator and checker behind a 64-bit soft-register interface.
module axis_strm_gen_chk
    import axis_strm_gen_chk_pkg::*;
#(
    parameter int unsigned DATA_W   = 512,
    parameter int unsigned NUM_DEST = 32,
    parameter int unsigned NUM_ID   = 32,
    parameter int unsigned CNT_W    = 35
) (
    input  logic        clk,
    input  logic        rst,
    input  SoftRegReq   softreg_req,
    output SoftRegResp  softreg_resp,
    output axi_stream_t axis_tx,
    input  logic        axis_tx_tready,
    input  axi_stream_t axis_rx,
    output logic        axis_rx_tready
);

    localparam logic [TDEST_W-1:0] DEST_MASK = TDEST_W'(NUM_DEST - 1);
    localparam int unsigned        RX_LAST_W = TID_W + 1 + PAT_W;

    gen_state_t             r_state;
    gen_state_t             w_state_nxt;
    logic [CNT_W-1:0]       r_tx_cnt;
    logic [CNT_W-1:0]       r_rx_cnt;
    logic [TDEST_W-1:0]     r_tx_dest;
    logic [TDEST_W-1:0]     r_dest;
    logic [IDX_W-1:0]       r_pkt_len;
    logic [GAP_W-1:0]       r_tx_gap;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [1:0]             r_ctrl;
    logic [IDX_W-1:0]       r_pkt;
    logic [IDX_W-1:0]       r_beat;
    logic [CYC_W-1:0]       r_tx_cyc;
    logic [CYC_W-1:0]       r_rx_cyc;
    logic [CNT_W-1:0]       r_rx_pkts;
    logic [ERR_W-1:0]       r_err_cnt;
    logic [RX_LAST_W-1:0]   r_rx_last;

    logic                   w_wr;
    logic                   w_rd;
    logic                   w_tx_cnt_wr;
    logic                   w_rx_cnt_wr;
    logic [CNT_W-1:0]       w_wdata_cnt;
    logic                   w_tx_vld;
    logic                   w_tx_last;
    logic                   w_tx_hs;
    logic                   w_rx_hs;
    logic                   w_err_pulse;
    logic [REG_DATA_W-1:0]  w_first_err;
    logic [REG_DATA_W-1:0]  w_rd_data;
    pat_t                   w_pat;
    logic                   w_unused;

    assign w_wr        = softreg_req.valid && softreg_req.isWrite;
    assign w_rd        = softreg_req.valid && !softreg_req.isWrite;
    assign w_tx_cnt_wr = w_wr && (softreg_req.addr == ADDR_TX_COUNT);
    assign w_rx_cnt_wr = w_wr && (softreg_req.addr == ADDR_RX_COUNT);
    assign w_wdata_cnt = softreg_req.data[CNT_W-1:0];
    assign w_tx_vld    = (r_state == ST_SEND);
    assign w_tx_last   = (r_beat == r_pkt_len);
    assign w_tx_hs     = w_tx_vld && axis_tx_tready;
    assign w_rx_hs     = axis_rx.tvalid && axis_rx_tready;

    assign axis_rx_tready = (r_rx_cnt != '0);
    assign w_unused = ^{softreg_req.data[REG_DATA_W-1:CNT_W], axis_rx.tdata[AXIS_DATA_W-1:PAT_W],
                        axis_rx.tdest};

    // Generated beat: the pattern word replicated across the configured data width.
    always_comb begin
        w_pat.pkt      = r_pkt;
        w_pat.beat     = r_beat;
        axis_tx        = '0;
        axis_tx.tvalid = w_tx_vld;
        axis_tx.tdest  = r_dest;
        axis_tx.tlast  = w_tx_vld && w_tx_last;
        for (int unsigned g = 0; g < AXIS_DATA_W / PAT_W; g++) begin
            if (g < DATA_W / PAT_W) begin
                axis_tx.tdata[g*PAT_W +: PAT_W] = pat_pack(w_pat);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A TX_COUNT write overrides the current state, including an in-progress gap.
    always_comb begin
        w_state_nxt = r_state;
        if (w_tx_cnt_wr) begin
            w_state_nxt = (w_wdata_cnt != '0) ? ST_SEND : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_tx_cnt != '0) begin
                        w_state_nxt = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_tx_hs) begin
                        if (r_tx_cnt == CNT_W'(1)) begin
                            w_state_nxt = ST_IDLE;
                        end else if (w_tx_last && (r_tx_gap != '0)) begin
                            w_state_nxt = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_tx_cnt == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_gap_cnt <= GAP_W'(1)) begin
                        w_state_nxt = ST_SEND;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Plain configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_dest <= '0;
            r_pkt_len <= '0;
            r_tx_gap  <= '0;
            r_ctrl    <= '0;
        end else if (w_wr) begin
            case (softreg_req.addr)
                ADDR_TX_DEST: r_tx_dest <= softreg_req.data[TDEST_W-1:0];
                ADDR_PKT_LEN: r_pkt_len <= softreg_req.data[IDX_W-1:0];
                ADDR_TX_GAP:  r_tx_gap  <= softreg_req.data[GAP_W-1:0];
                ADDR_CTRL:    r_ctrl    <= softreg_req.data[1:0];
                default: ;
            endcase
        end
    end

    // Generator datapath: count, packet/beat indices, destination and gap timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_cnt  <= '0;
            r_pkt     <= '0;
            r_beat    <= '0;
            r_dest    <= '0;
            r_tx_cyc  <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_tx_cnt_wr) begin
                r_tx_cnt <= w_wdata_cnt;
                r_pkt    <= '0;
                r_beat   <= '0;
                r_tx_cyc <= '0;
                r_dest   <= r_tx_dest;
            end else begin
                if (r_tx_cnt != '0) begin
                    r_tx_cyc <= r_tx_cyc + CYC_W'(1);
                end
                if (w_tx_hs) begin
                    r_tx_cnt <= r_tx_cnt - CNT_W'(1);
                    if (w_tx_last) begin
                        r_beat <= '0;
                        r_pkt  <= r_pkt + IDX_W'(1);
                        if (r_ctrl[CTRL_RR_DEST]) begin
                            r_dest <= (r_dest + TDEST_W'(1)) & DEST_MASK;
                        end
                    end else begin
                        r_beat <= r_beat + IDX_W'(1);
                    end
                end
            end
            if (w_tx_hs && w_tx_last) begin
                r_gap_cnt <= r_tx_gap;
            end else if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
        end
    end

    // Receive-side counters; an RX_COUNT write wins over a same-cycle beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_cnt  <= '0;
            r_rx_cyc  <= '0;
            r_rx_pkts <= '0;
            r_err_cnt <= '0;
            r_rx_last <= '0;
        end else if (w_rx_cnt_wr) begin
            r_rx_cnt  <= w_wdata_cnt;
            r_rx_cyc  <= '0;
            r_rx_pkts <= '0;
            r_err_cnt <= '0;
        end else begin
            if (r_rx_cnt != '0) begin
                r_rx_cyc <= r_rx_cyc + CYC_W'(1);
            end
            if (w_rx_hs) begin
                r_rx_cnt  <= r_rx_cnt - CNT_W'(1);
                r_rx_last <= {axis_rx.tid, axis_rx.tlast, axis_rx.tdata[PAT_W-1:0]};
                if (axis_rx.tlast) begin
                    r_rx_pkts <= r_rx_pkts + CNT_W'(1);
                end
            end
            if (w_err_pulse && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    axis_strm_chk #(
        .NUM_ID (NUM_ID)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_rx_cnt_wr),
        .i_chk_en    (r_ctrl[CTRL_CHK_EN]),
        .i_pkt_len   (r_pkt_len),
        .i_vld       (w_rx_hs),
        .i_tid       (axis_rx.tid),
        .i_word      (axis_rx.tdata[PAT_W-1:0]),
        .i_tlast     (axis_rx.tlast),
        .o_err_pulse (w_err_pulse),
        .o_first_err (w_first_err)
    );

    always_comb begin
        w_rd_data = '0;
        case (softreg_req.addr)
            ADDR_TX_COUNT:  w_rd_data = REG_DATA_W'(r_tx_cnt);
            ADDR_RX_COUNT:  w_rd_data = REG_DATA_W'(r_rx_cnt);
            ADDR_TX_DEST:   w_rd_data = REG_DATA_W'(r_tx_dest);
            ADDR_PKT_LEN:   w_rd_data = REG_DATA_W'(r_pkt_len);
            ADDR_TX_GAP:    w_rd_data = REG_DATA_W'(r_tx_gap);
            ADDR_CTRL:      w_rd_data = REG_DATA_W'(r_ctrl);
            ADDR_TX_CYC:    w_rd_data = REG_DATA_W'(r_tx_cyc);
            ADDR_RX_CYC:    w_rd_data = REG_DATA_W'(r_rx_cyc);
            ADDR_RX_PKTS:   w_rd_data = REG_DATA_W'(r_rx_pkts);
            ADDR_ERR_COUNT: w_rd_data = REG_DATA_W'(r_err_cnt);
            ADDR_FIRST_ERR: w_rd_data = w_first_err;
            ADDR_RX_LAST:   w_rd_data = REG_DATA_W'(r_rx_last);
            default:        w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            softreg_resp <= '0;
        end else begin
            softreg_resp.valid <= w_rd;
            softreg_resp.data  <= w_rd ? w_rd_data : '0;
        end
    end

endmodule
